reg_file_sb: RTL and testbench
==============================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: register and data width in bits.
REQ-002 SHALL have parameter NREGS, default 32: architectural register count; 16 for RV32E, and legal values are 16 or 32.
REQ-003 SHALL have parameter AW, default 5: register address width; NREGS <= 2**AW.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port ready, output, 1: high once the clear sequence completes.
REQ-007 SHALL have ports readRegister1 and readRegister2, input, AW each: read addresses.
REQ-008 SHALL have ports readData1 and readData2, output, XLEN each: read data.
REQ-009 SHALL have ports regWrite (input, 1), writeRegister (input, AW) and writeData (input, XLEN): writeback port.
REQ-010 SHALL have ports issueValid (input, 1) and issueRd (input, AW): marks a destination register pending.
REQ-011 SHALL have ports busy1 and busy2, output, 1 each: a pending write exists for readRegister1 or readRegister2.

Function
REQ-012 SHALL implement a two-state FSM, CLEAR and RUN; ready = (state == RUN).
REQ-013 In CLEAR with reset low, each edge SHALL write zero to reg[idx] and increment idx; the clear of idx == NREGS-1 SHALL move the FSM to RUN.
REQ-014 Consequently, ready SHALL rise exactly NREGS edges after reset deasserts.
REQ-015 While ready is low: regWrite and issueValid ignored; readData1/2 = 0; busy1/2 = 0.
REQ-016 Reads SHALL be combinational (zero latency); address 0 or an address >= NREGS SHALL read 0.
REQ-017 Write-through bypass: if regWrite, writeRegister == readRegisterN, and the address is nonzero and < NREGS, readDataN SHALL equal writeData in the same cycle.
REQ-018 In RUN, regWrite with writeRegister in 1..NREGS-1 SHALL update reg[writeRegister] at the edge; writes to 0 or to addresses >= NREGS SHALL be dropped.
REQ-019 Scoreboard: in RUN, issueValid with issueRd in 1..NREGS-1 SHALL set busy[issueRd] at the edge.
REQ-020 Scoreboard: in RUN, regWrite SHALL clear busy[writeRegister] at the edge.
REQ-021 When set and clear target the same register in one cycle, set SHALL win.
REQ-022 busyN SHALL equal busy[readRegisterN] AND NOT (regWrite AND writeRegister == readRegisterN), so a same-cycle writeback hides the pending flag; busy for register 0 SHALL always be 0.
REQ-023 Reads and writes SHALL be usable in the same cycle without stall; the block SHALL have no backpressure.

Reset
REQ-024 reset high SHALL, at the edge, force state = CLEAR, idx = 0 and all busy bits = 0; ready SHALL be 0 from that edge.
REQ-025 Register contents SHALL be cleared only by the CLEAR walk, one register per cycle, never in bulk, so storage maps to LUT-RAM or BRAM.
REQ-026 reset asserted mid-CLEAR or mid-RUN SHALL restart the walk from idx 0; any in-flight write that cycle SHALL be discarded.

Structure
REQ-027 A shared package SHALL hold the XLEN default, the NREGS_E (16) and NREGS_I (32) constants, and the FSM state enum.
REQ-028 The scoreboard SHALL be a sub-module reg_scoreboard, holding the busy bits and the set/clear/hide logic; storage and the FSM stay in reg_file_sb.

Verification
REQ-029 NREGS=32: deassert reset -> ready low for 32 edges, high on the 32nd; every register reads 0 on the first ready cycle.
REQ-030 Write x5 = 0xDEADBEEF with readRegister1 = 5 in the same cycle -> readData1 = 0xDEADBEEF combinationally and on all later reads.
REQ-031 Write x0 = 0x12345678 -> readData of x0 stays 0; NREGS=16: write x20 = 0x1 -> dropped, x20 reads 0.
REQ-032 issueValid with issueRd = 7 -> busy1 = 1 (readRegister1 = 7) next cycle; regWrite x7 -> busy1 = 0 that cycle, and 0 afterwards.
REQ-033 issueRd = 9 with regWrite x9 in the same cycle -> busy[9] = 1 afterwards.
REQ-034 Pulse reset for 1 cycle at clear idx 10 after x3 = 0xA5A5A5A5 was written -> ready low for 32 more edges; x3 reads 0; busy all 0.

Source files
------------

// File: rtl/reg_file_sb_pkg.sv
// Shared constants and FSM state encoding for the scoreboarded register file.
package reg_file_sb_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREGS_E  = 16;
  localparam int NREGS_I  = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write flags: set on issue, cleared on writeback (set wins).
// Outputs are combinational; a same-cycle writeback hides the pending flag.
module reg_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_en,
  input  logic          i_set_vld,
  input  logic [AW-1:0] i_set_rd,
  input  logic          i_clr_vld,
  input  logic [AW-1:0] i_clr_rd,
  input  logic [AW-1:0] i_rd1,
  input  logic [AW-1:0] i_rd2,
  output logic          o_busy1,
  output logic          o_busy2
);
  localparam int IW = $clog2(NREGS);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_set_ok;
  logic             w_clr_ok;
  logic             w_rd1_ok;
  logic             w_rd2_ok;

  assign w_set_ok = (32'(i_set_rd) < NREGS);
  assign w_clr_ok = (32'(i_clr_rd) < NREGS);
  assign w_rd1_ok = (32'(i_rd1) < NREGS);
  assign w_rd2_ok = (32'(i_rd2) < NREGS);

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_en && i_clr_vld && w_clr_ok) w_busy_nxt[i_clr_rd[IW-1:0]] = 1'b0;
    if (i_en && i_set_vld && w_set_ok) w_busy_nxt[i_set_rd[IW-1:0]] = 1'b1;
    // x0 is hardwired and never pending
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_busy <= '0;
    else         r_busy <= w_busy_nxt;
  end

  assign o_busy1 = i_en && w_rd1_ok && r_busy[i_rd1[IW-1:0]] &&
                   !(i_clr_vld && (i_clr_rd == i_rd1));
  assign o_busy2 = i_en && w_rd2_ok && r_busy[i_rd2[IW-1:0]] &&
                   !(i_clr_vld && (i_clr_rd == i_rd2));
endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with write-through bypass and a pending-write scoreboard.
// After reset the storage is zeroed one entry per cycle; ready rises when the walk ends.
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_I,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  output logic            ready,
  input  logic [AW-1:0]   readRegister1,
  input  logic [AW-1:0]   readRegister2,
  output logic [XLEN-1:0] readData1,
  output logic [XLEN-1:0] readData2,
  input  logic            regWrite,
  input  logic [AW-1:0]   writeRegister,
  input  logic [XLEN-1:0] writeData,
  input  logic            issueValid,
  input  logic [AW-1:0]   issueRd,
  output logic            busy1,
  output logic            busy2
);
  localparam int            IW       = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_idx, w_idx_nxt;
  logic [XLEN-1:0] r_regs [NREGS];

  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [XLEN-1:0] w_wdata;
  logic            w_ready;
  logic            w_wr_ok, w_rd1_ok, w_rd2_ok;

  assign w_ready  = (r_state == ST_RUN);
  assign ready    = w_ready;
  assign w_wr_ok  = (writeRegister != '0) && (32'(writeRegister) < NREGS);
  assign w_rd1_ok = (readRegister1 != '0) && (32'(readRegister1) < NREGS);
  assign w_rd2_ok = (readRegister2 != '0) && (32'(readRegister2) < NREGS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // The clear walk shares the single write port so storage stays RAM-shaped.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_we        = 1'b0;
    w_waddr     = writeRegister;
    w_wdata     = writeData;
    case (r_state)
      ST_CLEAR: begin
        w_we      = 1'b1;
        w_waddr   = r_idx;
        w_wdata   = '0;
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_RUN;
          w_idx_nxt   = '0;
        end
      end
      ST_RUN:  w_we = regWrite && w_wr_ok;
      default: w_state_nxt = ST_CLEAR;
    endcase
    if (reset) w_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_we) r_regs[w_waddr[IW-1:0]] <= w_wdata;
  end

  assign readData1 = (!w_ready || !w_rd1_ok) ? '0 :
                     (regWrite && (writeRegister == readRegister1)) ? writeData :
                     r_regs[readRegister1[IW-1:0]];
  assign readData2 = (!w_ready || !w_rd2_ok) ? '0 :
                     (regWrite && (writeRegister == readRegister2)) ? writeData :
                     r_regs[readRegister2[IW-1:0]];

  reg_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_en      (w_ready),
    .i_set_vld (issueValid),
    .i_set_rd  (issueRd),
    .i_clr_vld (regWrite),
    .i_clr_rd  (writeRegister),
    .i_rd1     (readRegister1),
    .i_rd2     (readRegister2),
    .o_busy1   (busy1),
    .o_busy2   (busy2)
  );
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a 32-entry instance checked against tables and an array model,
// plus a 16-entry instance for the out-of-range write cases.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        reset;

  logic        ready, rw, iv, b1, b2;
  logic [4:0]  rr1, rr2, wr, ird;
  logic [31:0] rd1, rd2, wd;

  logic        ready_s, rw_s, iv_s, b1_s, b2_s;
  logic [4:0]  rr1_s, rr2_s, wr_s, ird_s;
  logic [31:0] rd1_s, rd2_s, wd_s;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2;
    logic        eb1, eb2;
  } vec_t;
  vec_t tbl [12];

  reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .ready(ready),
    .readRegister1(rr1), .readRegister2(rr2), .readData1(rd1), .readData2(rd2),
    .regWrite(rw), .writeRegister(wr), .writeData(wd),
    .issueValid(iv), .issueRd(ird), .busy1(b1), .busy2(b2)
  );

  reg_file_sb #(.XLEN(32), .NREGS(16), .AW(5)) dut16 (
    .clk(clk), .reset(reset), .ready(ready_s),
    .readRegister1(rr1_s), .readRegister2(rr2_s), .readData1(rd1_s), .readData2(rd2_s),
    .regWrite(rw_s), .writeRegister(wr_s), .writeData(wd_s),
    .issueValid(iv_s), .issueRd(ird_s), .busy1(b1_s), .busy2(b2_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rw = 1'b0; wr = '0; wd = '0; iv = 1'b0; ird = '0; rr1 = '0; rr2 = '0;
    rw_s = 1'b0; wr_s = '0; wd_s = '0; iv_s = 1'b0; ird_s = '0; rr1_s = '0; rr2_s = '0;
  endtask

  // Architectural effect of one RUN-state edge on the 32-entry instance.
  task automatic model_step();
    if (rw && wr != 0) m_regs[wr] = wd;
    if (rw) m_busy[wr] = 1'b0;
    if (iv && ird != 0) m_busy[ird] = 1'b1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (rw && wr == a) return wd;
    return m_regs[a];
  endfunction

  function automatic logic exp_b(input logic [4:0] a);
    return (a != 0) && m_busy[a] && !(rw && wr == a);
  endfunction

  initial begin
    tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h0, 32'h0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 5'd7, 5'd5, 32'h77, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h77, 32'h77, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 5'd9, 32'h99,       1'b1, 5'd9, 5'd9, 5'd7, 32'h99, 32'h77, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd0, 32'h99, 32'h0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd9, 32'h0, 32'h99, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd9, 32'h0, 32'h99, 1'b0, 1'b1};

    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_ready16", 32'(ready_s), 32'h0);

    // Walk after reset release; writes and issues must be ignored throughout.
    reset = 1'b0;
    rw = 1'b1; wr = 5'd5; wd = 32'hFFFF0000; iv = 1'b1; ird = 5'd6; rr1 = 5'd5; rr2 = 5'd6;
    for (int e = 1; e <= 32; e++) begin
      chk("walk_rd1", rd1, 32'h0);
      chk("walk_busy2", 32'(b2), 32'h0);
      tick();
      if (e == 32) idle();
      chk($sformatf("ready_edge%0d", e), 32'(ready), 32'(e >= 32));
      chk($sformatf("ready16_edge%0d", e), 32'(ready_s), 32'(e >= 16));
    end
    idle();
    for (int a = 0; a < 32; a++) begin
      rr1 = 5'(a); rr2 = 5'(31 - a);
      #1;
      chk($sformatf("clear_x%0d", a), rd1, 32'h0);
      chk("clear_rd2", rd2, 32'h0);
      chk("clear_busy1", 32'(b1), 32'h0);
    end
    for (int a = 0; a < 32; a++) begin
      m_regs[a] = '0;
      m_busy[a] = 1'b0;
    end

    // 16-entry instance: out-of-range writes dropped, top entry usable.
    rw_s = 1'b1; wr_s = 5'd20; wd_s = 32'h1; rr1_s = 5'd20;
    #1 chk("r16_byp_x20", rd1_s, 32'h0);
    tick();
    rw_s = 1'b1; wr_s = 5'd15; wd_s = 32'h55; rr1_s = 5'd15;
    #1 chk("r16_byp_x15", rd1_s, 32'h55);
    tick();
    idle();
    rr1_s = 5'd20; rr2_s = 5'd4;
    #1 chk("r16_x20", rd1_s, 32'h0);
    chk("r16_x4_alias", rd2_s, 32'h0);
    rr1_s = 5'd15;
    #1 chk("r16_x15", rd1_s, 32'h55);

    for (int i = 0; i < 12; i++) begin
      rw = tbl[i].rw; wr = tbl[i].wr; wd = tbl[i].wd;
      iv = tbl[i].iv; ird = tbl[i].ird; rr1 = tbl[i].a1; rr2 = tbl[i].a2;
      #1;
      chk($sformatf("tbl%0d_rd1", i), rd1, tbl[i].e1);
      chk($sformatf("tbl%0d_rd2", i), rd2, tbl[i].e2);
      chk($sformatf("tbl%0d_b1", i), 32'(b1), 32'(tbl[i].eb1));
      chk($sformatf("tbl%0d_b2", i), 32'(b2), 32'(tbl[i].eb2));
      model_step();
      tick();
    end

    for (int i = 0; i < 400; i++) begin
      rw  = 1'($urandom);
      wr  = 5'($urandom);
      wd  = $urandom;
      iv  = ($urandom_range(2) == 0);
      ird = ($urandom_range(3) == 0) ? wr : 5'($urandom);
      rr1 = ($urandom_range(3) == 0) ? wr : 5'($urandom);
      rr2 = ($urandom_range(3) == 0) ? ird : 5'($urandom);
      #1;
      chk("rnd_rd1", rd1, exp_rd(rr1));
      chk("rnd_rd2", rd2, exp_rd(rr2));
      chk("rnd_b1", 32'(b1), 32'(exp_b(rr1)));
      chk("rnd_b2", 32'(b2), 32'(exp_b(rr2)));
      model_step();
      tick();
    end

    // Reset during the clear walk restarts it and discards the in-flight write.
    idle();
    rw = 1'b1; wr = 5'd3; wd = 32'hA5A5A5A5; iv = 1'b1; ird = 5'd4;
    tick();
    idle();
    rr1 = 5'd3; rr2 = 5'd4;
    #1 chk("x3_written", rd1, 32'hA5A5A5A5);
    chk("x4_busy", 32'(b2), 32'h1);
    reset = 1'b1;
    tick();
    chk("rst_ready_low", 32'(ready), 32'h0);
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("walk1_ready", 32'(ready), 32'h0);
    end
    reset = 1'b1; rw = 1'b1; wr = 5'd3; wd = 32'h0BADF00D;
    tick();
    idle();
    reset = 1'b0;
    chk("rst2_ready_low", 32'(ready), 32'h0);
    for (int e = 1; e <= 32; e++) begin
      tick();
      chk($sformatf("restart_ready_edge%0d", e), 32'(ready), 32'(e >= 32));
    end
    for (int a = 0; a < 32; a++) begin
      rr1 = 5'(a); rr2 = 5'(a);
      #1;
      chk($sformatf("post_rst_x%0d", a), rd1, 32'h0);
      chk($sformatf("post_rst_busy%0d", a), 32'(b2), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
